// File: rtl/core_launcher.sv
// Launch sequencer for a compute core: holds the core in reset, pulses a start
// request, then times the run until done or a cycle-count timeout.
module core_launcher #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1000,
  parameter int RST_CYC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   prog_sel,
  input  logic         done,
  output logic         core_reset,
  output logic         req,
  output logic [1:0]   run_prog,
  output logic         busy,
  output logic         run_done,
  output logic         timed_out,
  output logic [W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CRST = 3'd1,
    S_REQ  = 3'd2,
    S_RUN  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [3:0]   RST_LAST = 4'(RST_CYC - 1);
  localparam logic [W-1:0] TO_VAL   = W'(TIMEOUT);

  state_t       state_q, state_d;
  logic [3:0]   rst_cnt_q, rst_cnt_d;
  logic [W-1:0] count_q, count_d;
  logic         timed_out_q, timed_out_d;
  logic [1:0]   prog_q, prog_d;
  logic         core_reset_q, core_reset_d;
  logic         req_q, req_d;
  logic         busy_q, busy_d;
  logic         run_done_q, run_done_d;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    count_d     = count_q;
    timed_out_d = timed_out_q;
    prog_d      = prog_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          prog_d      = prog_sel;
          timed_out_d = 1'b0;
          count_d     = '0;
          rst_cnt_d   = 4'd0;
          state_d     = S_CRST;
        end
      end
      S_CRST: begin
        if (rst_cnt_q == RST_LAST) state_d = S_REQ;
        else                       rst_cnt_d = rst_cnt_q + 4'd1;
      end
      S_REQ: state_d = S_RUN;
      S_RUN: begin
        // done has priority over an expiring timeout in the same cycle
        if (done) begin
          state_d = S_FIN;
        end else if (count_q == TO_VAL) begin
          timed_out_d = 1'b1;
          state_d     = S_FIN;
        end else begin
          count_d = count_q + W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Output flops are loaded from the next state so they align with state_q.
    core_reset_d = (state_d == S_IDLE) || (state_d == S_CRST);
    req_d        = (state_d == S_REQ);
    busy_d       = (state_d != S_IDLE);
    run_done_d   = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= 4'd0;
      count_q      <= '0;
      timed_out_q  <= 1'b0;
      prog_q       <= 2'd0;
      core_reset_q <= 1'b1;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      count_q      <= count_d;
      timed_out_q  <= timed_out_d;
      prog_q       <= prog_d;
      core_reset_q <= core_reset_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      run_done_q   <= run_done_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign req         = req_q;
  assign run_prog    = prog_q;
  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_core_launcher.sv
// Randomized bench for core_launcher; a run-level model predicts phase lengths,
// final count and timeout flag from the number of done-low RUN cycles.
module tb_core_launcher;

  localparam int W  = 16;
  localparam int TO = 8;
  localparam int RC = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   prog_sel;
  logic         done;
  logic         core_reset;
  logic         req;
  logic [1:0]   run_prog;
  logic         busy;
  logic         run_done;
  logic         timed_out;
  logic [W-1:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;
  int last_cnt = 0;
  int last_to  = 0;

  core_launcher #(.W(W), .TIMEOUT(TO), .RST_CYC(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .done(done),
    .core_reset(core_reset), .req(req), .run_prog(run_prog), .busy(busy),
    .run_done(run_done), .timed_out(timed_out), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One launch: the core raises done after n done-low RUN cycles.
  task automatic run_one(input logic [1:0] prog, input int n, input bit noisy);
    int crst, runc, guard, exp_cnt, exp_to;
    exp_cnt = (n > TO) ? TO : n;
    exp_to  = (n > TO) ? 1 : 0;
    start    = 1'b1;
    prog_sel = prog;
    done     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    start    = 1'b0;
    prog_sel = 2'($urandom);
    crst = 0;
    guard = 0;
    while (!req && guard < 40) begin
      check_val("crst_core_reset", core_reset, 1);
      check_val("crst_busy", busy, 1);
      crst++;
      guard++;
      if (noisy) begin
        done  = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      step();
    end
    check_val("crst_len", crst, RC);
    check_val("req_core_reset", core_reset, 0);
    check_val("req_prog", run_prog, prog);
    if (noisy) begin
      done  = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
    end
    step();
    runc = 0;
    guard = 0;
    while (!run_done && guard < 100) begin
      check_val("run_req", req, 0);
      check_val("run_core_reset", core_reset, 0);
      check_val("run_busy", busy, 1);
      check_val("run_cnt", cycle_count, runc);
      done  = (runc == n);
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      runc++;
      guard++;
      step();
    end
    start = 1'b0;
    check_val("run_len", runc, exp_cnt + 1);
    check_val("fin_run_done", run_done, 1);
    check_val("fin_count", cycle_count, exp_cnt);
    check_val("fin_timed_out", timed_out, exp_to);
    check_val("fin_prog", run_prog, prog);
    check_val("fin_busy", busy, 1);
    done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    check_val("post_run_done", run_done, 0);
    check_val("post_busy", busy, 0);
    check_val("post_core_reset", core_reset, 1);
    check_val("post_count", cycle_count, exp_cnt);
    check_val("post_timed_out", timed_out, exp_to);
    last_cnt = exp_cnt;
    last_to  = exp_to;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      start = 1'b0;
      done  = 1'($urandom_range(0, 1));
      step();
      check_val("idle_busy", busy, 0);
      check_val("idle_run_done", run_done, 0);
      check_val("idle_count_hold", cycle_count, last_cnt);
      check_val("idle_to_hold", timed_out, last_to);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_core_reset"}, core_reset, 1);
    check_val({tag, "_req"}, req, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_run_done"}, run_done, 0);
    check_val({tag, "_timed_out"}, timed_out, 0);
    check_val({tag, "_count"}, cycle_count, 0);
    check_val({tag, "_prog"}, run_prog, 0);
  endtask

  initial begin
    int guard;
    reset = 1'b0; start = 1'b0; done = 1'b0; prog_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    #2 reset = 1'b1;
    step();
    last_cnt = 0;
    last_to  = 0;
    // Stale done in IDLE must not launch anything.
    idle_cycles(3);

    run_one(2'd2, 5, 1'b0);
    run_one(2'd1, 20, 1'b0);
    run_one(2'd3, TO, 1'b0);
    run_one(2'd0, 0, 1'b1);
    run_one(2'd1, TO + 1, 1'b1);

    // Abort mid-RUN with an asynchronous reset.
    start = 1'b1; prog_sel = 2'd3; done = 1'b0;
    step();
    start = 1'b0;
    guard = 0;
    while (!(busy && !req && !core_reset && cycle_count == 3) && guard < 40) begin
      guard++;
      step();
    end
    check_val("abort_reach_cnt3", cycle_count, 3);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("abort");
    step();
    check_val("abort_no_run_done", run_done, 0);
    #2 reset = 1'b1;
    step();
    check_val("abort_after_busy", busy, 0);
    check_val("abort_after_run_done", run_done, 0);
    last_cnt = 0;
    last_to  = 0;
    run_one(2'd2, 3, 1'b0);

    for (int r = 0; r < 25; r++) begin
      run_one(2'($urandom), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_launcher.md
CORE_LAUNCHER -- requirements
Module: core_launcher

Interface
REQ-001 Parameter W, default 16, SHALL set the cycle-counter width.
REQ-002 Parameter TIMEOUT, default 1000, SHALL set the maximum number of RUN cycles before abort; legal range 1 to 2^W-1.
REQ-003 Parameter RST_CYC, default 2, SHALL set the number of cycles core_reset is held; legal range 1 to 15.
REQ-004 clk  input  1  SHALL be the single rising-edge clock.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL be the host launch request, sampled high for one cycle.
REQ-007 prog_sel  input  2  SHALL be the program index, captured when start is accepted.
REQ-008 done  input  1  SHALL be the core completion flag (level).
REQ-009 core_reset  output  1  SHALL be the synchronous, active-high reset for the core.
REQ-010 req  output  1  SHALL be the core start request.
REQ-011 run_prog  output  2  SHALL be the latched program index presented to the core.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 run_done  output  1  SHALL be a one-cycle completion pulse.
REQ-014 timed_out  output  1  SHALL be the sticky abort flag for the last run.
REQ-015 cycle_count  output  W  SHALL report the RUN-cycle count of the last run.

Function
REQ-016 The FSM SHALL have the states IDLE, CRST, REQ, RUN and FIN.
REQ-017 IDLE: start=1 SHALL latch prog_sel into run_prog, clear timed_out, clear cycle_count and move to CRST; otherwise the FSM SHALL stay in IDLE.
REQ-018 CRST: core_reset SHALL be 1 for exactly RST_CYC consecutive cycles, after which the FSM SHALL move to REQ.
REQ-019 REQ: req SHALL be 1 for exactly one cycle and core_reset SHALL be 0; the FSM SHALL then move to RUN.
REQ-020 RUN: cycle_count SHALL increment by 1 on every RUN cycle in which done is 0.
REQ-021 RUN: done=1 SHALL move the FSM to FIN without incrementing cycle_count.
REQ-022 RUN: if cycle_count equals TIMEOUT and done is 0, the FSM SHALL set timed_out=1 and move to FIN.
REQ-023 RUN: if done=1 in the same cycle the timeout condition is met, done SHALL win and timed_out SHALL stay 0.
REQ-024 FIN: run_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 cycle_count and timed_out SHALL hold their values until the next accepted start.
REQ-026 start SHALL be ignored in every state other than IDLE.
REQ-027 done=1 while in IDLE, CRST or REQ SHALL be ignored.
REQ-028 done SHALL be sampled only in RUN, so a stale done left over from a previous run cannot end a new run before REQ.
REQ-029 cycle_count SHALL never wrap, which the TIMEOUT bound guarantees.
REQ-030 A start accepted in the cycle after FIN SHALL launch a new run with no extra idle cycle.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 reset=0 SHALL, asynchronously, force IDLE, core_reset=1, req=0, busy=0, run_done=0, timed_out=0, cycle_count=0 and run_prog=0.
REQ-033 core_reset SHALL stay at 1 in IDLE, holding the core in reset while no run is active.
REQ-034 Deassertion of reset SHALL take effect on the next rising clk edge.
REQ-035 reset asserted mid-run SHALL abort the run without producing a run_done pulse.

Verification
REQ-036 Normal run: start with prog_sel=2, done rises 5 cycles after req -> core_reset high 2 cycles, req 1 cycle, cycle_count=5, run_done 1 cycle, run_prog=2, timed_out=0.
REQ-037 Timeout: TIMEOUT=8, done held 0 -> timed_out=1, cycle_count=8, single run_done pulse, return to IDLE.
REQ-038 Simultaneous events: done=1 in the cycle cycle_count reaches TIMEOUT -> timed_out=0, run_done pulse.
REQ-039 Ignored inputs: start pulsed during RUN and done=1 in IDLE and CRST -> no restart, no early FIN, cycle_count matches the first run only.
REQ-040 Reset mid-RUN: reset=0 at cycle_count=3 -> all outputs at reset values immediately, no run_done; a later start runs normally.
REQ-041 Back-to-back runs: start in the cycle after run_done -> second run starts with CRST, cycle_count restarts at 0.
